instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter TIMEOUT, default 16, max BUSY cycles without imem_ack before fetch fault; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low (asserted at 0).
REQ-004 PC  input  32  current program counter; bits [1:0] ignored.
REQ-005 fetch_en  input  1  controller requests next instruction fetch.
REQ-006 flush  input  1  abandon outstanding or held fetch; priority over fetch_en.
REQ-007 imem_req  output  1  instruction-memory request, held until imem_ack.
REQ-008 imem_addr  output  32  word address {PC[31:2],2'b00}, registered.
REQ-009 imem_ack  input  1  memory response strobe, one cycle; data valid same cycle.
REQ-010 imem_rdata  input  32  instruction word from memory.
REQ-011 IR  output  32  instruction register.
REQ-012 ir_valid  output  1  IR holds an undelivered instruction.
REQ-013 ir_ready  input  1  decode consumes IR this cycle when ir_valid=1.
REQ-014 PCWr  output  1  one-cycle pulse to PC register to load NPC.
REQ-015 fetch_err  output  1  sticky timeout fault.
REQ-016 fetch_cnt  output  32  count of instructions delivered to IR.

Function
REQ-017 FSM states: IDLE, BUSY, FULL, DROP; all outputs registered.
REQ-018 IDLE: fetch_en=1, flush=0, fetch_err=0 -> latch imem_addr={PC[31:2],2'b00}, imem_req=1, timer=0, go BUSY next edge.
REQ-019 IDLE with fetch_err=1: fetch_en ignored until flush or reset.
REQ-020 BUSY: imem_req and imem_addr held stable; timer increments each cycle imem_ack=0.
REQ-021 BUSY, imem_ack=1, flush=0: IR<=imem_rdata, ir_valid<=1, PCWr<=1 for exactly one cycle, imem_req<=0, fetch_cnt+1 (wraps 0xFFFF_FFFF->0), go FULL.
REQ-022 Latency: ack at edge N -> IR/ir_valid/PCWr visible after edge N; PC register loads NPC at edge N+1.
REQ-023 BUSY, timer reaches TIMEOUT-1 with imem_ack=0: imem_req<=0, fetch_err<=1, go IDLE; no PCWr, IR unchanged.
REQ-024 BUSY, flush=1 without ack: go DROP, imem_req stays 1; DROP ends on imem_ack (data discarded, no PCWr, no count) -> IDLE.
REQ-025 BUSY, flush=1 and imem_ack=1 same cycle: data discarded, no PCWr, go IDLE.
REQ-026 DROP: timeout applies; expiry -> IDLE with imem_req=0, fetch_err unchanged.
REQ-027 FULL: IR, ir_valid=1 held until ir_ready=1.
REQ-028 FULL, ir_ready=1, fetch_en=1, flush=0: ir_valid<=0, new request issued same edge (back-to-back) using current PC, go BUSY.
REQ-029 FULL, ir_ready=1, fetch_en=0: ir_valid<=0, go IDLE.
REQ-030 FULL, flush=1: ir_valid<=0 regardless of ir_ready, go IDLE; IR value retained.
REQ-031 flush=1 clears fetch_err; takes effect same edge.
REQ-032 PCWr never asserted in two consecutive cycles.

Reset
REQ-033 rst=0 immediately (no clock): state IDLE, imem_req=0, imem_addr=0, IR=0, ir_valid=0, PCWr=0, fetch_err=0, fetch_cnt=0, timer=0.
REQ-034 Reset during BUSY/DROP drops imem_req asynchronously; any later imem_ack while IDLE is ignored.
REQ-035 First fetch permitted on first rising edge with rst=1.

Verification
REQ-036 PC=0x0000_3000, fetch_en=1, ack after 2 cycles with rdata=0x2008_0005 -> imem_addr=0x0000_3000, IR=0x2008_0005, ir_valid=1, one PCWr pulse, fetch_cnt=1.
REQ-037 PC=0x0000_3003 -> imem_addr=0x0000_3000.
REQ-038 TIMEOUT=16, no ack -> imem_req falls after 16 BUSY cycles, fetch_err=1, fetch_en ignored; flush -> fetch_err=0.
REQ-039 Flush 1 cycle after request, ack 3 cycles later -> no PCWr, ir_valid stays 0, fetch_cnt unchanged, state IDLE.
REQ-040 FULL with ir_ready=1 and fetch_en=1 -> imem_req=1 next cycle with new PC, ir_valid=0; 3 back-to-back fetches -> fetch_cnt=3, 3 isolated PCWr pulses.
REQ-041 rst=0 mid-BUSY -> imem_req=0 without clock edge, all outputs at reset values.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch controller: issues one word request per fetch, holds the
// returned instruction in IR until decode takes it, and flags memory timeouts.
module instr_fetch #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        PCWr,
    output logic        fetch_err,
    output logic [31:0] fetch_cnt
);
    // state | meaning
    // IDLE  | no request outstanding, IR empty or already consumed
    // BUSY  | request outstanding, response will be captured
    // FULL  | IR holds an instruction waiting for decode
    // DROP  | request outstanding after flush, response will be discarded
    typedef enum logic [1:0] {IDLE, BUSY, FULL, DROP} state_t;

    localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [7:0]  timer, timer_nx;
    logic        req_nx, valid_nx, pcwr_nx, err_nx;
    logic [31:0] addr_nx, ir_nx, cnt_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            timer     <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            IR        <= '0;
            ir_valid  <= 1'b0;
            PCWr      <= 1'b0;
            fetch_err <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            imem_req  <= req_nx;
            imem_addr <= addr_nx;
            IR        <= ir_nx;
            ir_valid  <= valid_nx;
            PCWr      <= pcwr_nx;
            fetch_err <= err_nx;
            fetch_cnt <= cnt_nx;
        end
    end

    // Timer counts down from TIMEOUT-1; zero with no ack is the final BUSY cycle.
    always_comb begin
        state_nx = state;
        timer_nx = timer;
        req_nx   = imem_req;
        addr_nx  = imem_addr;
        ir_nx    = IR;
        valid_nx = ir_valid;
        pcwr_nx  = 1'b0;
        err_nx   = fetch_err;
        cnt_nx   = fetch_cnt;
        if (flush) err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en && !flush && !fetch_err) begin
                    req_nx   = 1'b1;
                    addr_nx  = {PC[31:2], 2'b00};
                    timer_nx = TMR_LOAD;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (imem_ack) begin
                    req_nx = 1'b0;
                    if (flush) begin
                        state_nx = IDLE;
                    end else begin
                        ir_nx    = imem_rdata;
                        valid_nx = 1'b1;
                        pcwr_nx  = 1'b1;
                        cnt_nx   = fetch_cnt + 32'd1;
                        state_nx = FULL;
                    end
                end else if (timer == 8'd0) begin
                    req_nx   = 1'b0;
                    err_nx   = !flush;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - 8'd1;
                    if (flush) state_nx = DROP;
                end
            end
            DROP: begin
                if (imem_ack || timer == 8'd0) begin
                    req_nx   = 1'b0;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer - 8'd1;
                end
            end
            FULL: begin
                if (flush) begin
                    valid_nx = 1'b0;
                    state_nx = IDLE;
                end else if (ir_ready) begin
                    valid_nx = 1'b0;
                    if (fetch_en) begin
                        req_nx   = 1'b1;
                        addr_nx  = {PC[31:2], 2'b00};
                        timer_nx = TMR_LOAD;
                        state_nx = BUSY;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; deliveries are checked by a scoreboard monitor.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] PC = '0;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] IR;
    logic        ir_valid;
    logic        ir_ready = 1'b0;
    logic        PCWr;
    logic        fetch_err;
    logic [31:0] fetch_cnt;

    instr_fetch #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .PC(PC), .fetch_en(fetch_en), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .IR(IR), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .PCWr(PCWr), .fetch_err(fetch_err),
        .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] cnt;
        logic [31:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   pcwr_pulses = 0;
    logic pcwr_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every PCWr pulse is a delivery and must match the queue head.
    always @(negedge clk) begin
        if (PCWr) begin
            pcwr_pulses++;
            check("pcwr_not_consecutive", 32'(pcwr_prev), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_delivery", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_ir", IR, e.ir);
                check("sb_fetch_cnt", fetch_cnt, e.cnt);
                check("sb_imem_addr", imem_addr, e.addr);
                check("sb_ir_valid", 32'(ir_valid), 32'd1);
            end
        end
        pcwr_prev = PCWr;
    end

    task automatic push(input logic [31:0] ir, input logic [31:0] cnt, input logic [31:0] addr);
        exp_t e;
        e.ir = ir; e.cnt = cnt; e.addr = addr;
        exp_q.push_back(e);
    endtask

    initial begin
        int p0;
        #2;
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_addr", imem_addr, 32'd0);
        check("reset_ir", IR, 32'd0);
        check("reset_cnt", fetch_cnt, 32'd0);
        #10 rst = 1'b1;
        tick();

        // Basic fetch, ack on the second BUSY cycle.
        PC = 32'h0000_3000; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t1_req", 32'(imem_req), 32'd1);
        check("t1_addr", imem_addr, 32'h0000_3000);
        tick();
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005;
        push(32'h2008_0005, 32'd1, 32'h0000_3000);
        tick();
        imem_ack = 1'b0;
        check("t1_req_drop", 32'(imem_req), 32'd0);
        tick();
        check("t1_pcwr_once", 32'(PCWr), 32'd0);
        check("t1_hold_valid", 32'(ir_valid), 32'd1);
        ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;
        check("t1_consumed", 32'(ir_valid), 32'd0);

        // Misaligned PC is word aligned.
        PC = 32'h0000_3003; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t2_addr", imem_addr, 32'h0000_3000);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        push(32'hDEAD_BEEF, 32'd2, 32'h0000_3000);
        tick();
        imem_ack = 1'b0; ir_ready = 1'b1;
        tick();
        ir_ready = 1'b0;

        // Timeout: 16 BUSY cycles, sticky error, fetch_en ignored, flush clears.
        PC = 32'h0000_4000; fetch_en = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("t3_req_before_to", 32'(imem_req), 32'd1);
        tick();
        check("t3_req_after_to", 32'(imem_req), 32'd0);
        check("t3_err", 32'(fetch_err), 32'd1);
        check("t3_ir_kept", IR, 32'hDEAD_BEEF);
        tick(); tick();
        check("t3_fetch_ignored", 32'(imem_req), 32'd0);
        fetch_en = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t3_err_cleared", 32'(fetch_err), 32'd0);

        // Flush one cycle after the request; late ack is discarded.
        PC = 32'h0000_5000; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t4_drop_req", 32'(imem_req), 32'd1);
        tick(); tick();
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        tick();
        imem_ack = 1'b0;
        check("t4_req", 32'(imem_req), 32'd0);
        check("t4_valid", 32'(ir_valid), 32'd0);
        check("t4_cnt", fetch_cnt, 32'd2);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("t4_idle_ack_ignored", 32'(ir_valid), 32'd0);

        // Three back-to-back fetches.
        p0 = pcwr_pulses;
        PC = 32'h0000_6000; fetch_en = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            imem_ack = 1'b1; imem_rdata = 32'hA000_0000 + 32'(k);
            push(32'hA000_0000 + 32'(k), 32'(3 + k), 32'h0000_6000 + 32'(4 * k));
            tick();
            imem_ack = 1'b0;
            PC = 32'h0000_6004 + 32'(4 * k);
            ir_ready = 1'b1;
            fetch_en = (k < 2);
            tick();
            ir_ready = 1'b0;
            check("t5_valid_cleared", 32'(ir_valid), 32'd0);
            if (k < 2) begin
                check("t5_b2b_req", 32'(imem_req), 32'd1);
                check("t5_b2b_addr", imem_addr, 32'h0000_6004 + 32'(4 * k));
            end
        end
        fetch_en = 1'b0;
        check("t5_cnt", fetch_cnt, 32'd5);
        check("t5_pulses", 32'(pcwr_pulses - p0), 32'd3);

        // Flush while FULL keeps IR value.
        PC = 32'h0000_6100; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
        push(32'h5555_AAAA, 32'd6, 32'h0000_6100);
        tick();
        imem_ack = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t6_valid", 32'(ir_valid), 32'd0);
        check("t6_ir_kept", IR, 32'h5555_AAAA);

        // Asynchronous reset mid-BUSY.
        PC = 32'h0000_7000; fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t7_req", 32'(imem_req), 32'd0);
        check("t7_addr", imem_addr, 32'd0);
        check("t7_ir", IR, 32'd0);
        check("t7_cnt", fetch_cnt, 32'd0);
        tick();
        rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        tick();
        imem_ack = 1'b0;
        check("t7_ack_ignored", 32'(ir_valid), 32'd0);
        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
